// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// State enum, address field offsets, line width and backing-store sizing.
package dcache_pkg;

  localparam int LINE_ADDR_LEN   = 3;
  localparam int SET_ADDR_LEN    = 3;
  localparam int TAG_ADDR_LEN    = 5;
  localparam int DEF_MEM_LATENCY = 8;

  localparam int WORD_LSB   = 2;
  localparam int SET_LSB    = WORD_LSB + LINE_ADDR_LEN;
  localparam int TAG_LSB    = SET_LSB + SET_ADDR_LEN;
  localparam int TAG_MSB    = TAG_LSB + TAG_ADDR_LEN - 1;

  localparam int NSETS      = 1 << SET_ADDR_LEN;
  localparam int LINE_W     = 32 * (1 << LINE_ADDR_LEN);
  localparam int LINE_IDX_W = LINE_ADDR_LEN + 5;
  localparam int MEM_LINE_W = TAG_ADDR_LEN + SET_ADDR_LEN;
  localparam int MEM_LINES  = 1 << MEM_LINE_W;

  typedef enum logic [1:0] {
    IDLE,
    SWAP_OUT,
    SWAP_IN,
    SWAP_IN_OK
  } state_t;

  typedef logic [TAG_ADDR_LEN-1:0]  tag_t;
  typedef logic [SET_ADDR_LEN-1:0]  set_t;
  typedef logic [LINE_ADDR_LEN-1:0] word_t;
  typedef logic [MEM_LINE_W-1:0]    mline_t;
  typedef logic [LINE_W-1:0]        line_t;

endpackage

// File: rtl/dcache_dm_responder_line_mem.sv
// Backing line store: single port, start/done handshake, MEM_LATENCY cycles.
// Ports: start/we/line_addr/wdata in; done, rdata (valid while done) out.
module line_mem_model
  import dcache_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   we,
  input  mline_t line_addr,
  input  line_t  wdata,
  output logic   done,
  output line_t  rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  line_t             mem [MEM_LINES];
  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic              op_we;
  mline_t            op_addr;
  line_t             op_wdata;

  assign done  = busy && (cnt == '0);
  assign rdata = mem[op_addr];

  // A start issued in the same cycle as done begins the next transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      op_we   <= 1'b0;
      op_addr <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= CNT_W'(MEM_LATENCY - 1);
      op_we   <= we;
      op_addr <= line_addr;
    end else if (done) begin
      busy    <= 1'b0;
    end else if (busy) begin
      cnt     <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start)
      op_wdata <= wdata;
    if (done && op_we)
      mem[op_addr] <= op_wdata;
  end

endmodule

// File: rtl/dcache_dm_responder.sv
// Direct-mapped write-back write-allocate data cache with backing store.
// Ports: addr/rd_req/wr_req/wr_be/wr_data in; rd_data (registered), miss.
// DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_dm_responder
  import dcache_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  word_t  word;
  set_t   set;
  tag_t   tag;
  logic   unused_addr;

  assign word = addr[WORD_LSB +: LINE_ADDR_LEN];
  assign set  = addr[SET_LSB +: SET_ADDR_LEN];
  assign tag  = addr[TAG_LSB +: TAG_ADDR_LEN];
  assign unused_addr = ^{addr[31:TAG_MSB+1], addr[1:0]};

  state_t          state, state_nx;
  logic [NSETS-1:0] valid, dirty;
  tag_t            tag_arr [NSETS];
  line_t           data [NSETS];
  tag_t            req_tag;
  set_t            req_set;

  logic   req, hit, serve, start_miss;
  logic   mem_start, mem_we, mem_done;
  mline_t mem_line;
  line_t  mem_rdata;

  assign req        = rd_req | wr_req;
  assign hit        = valid[set] && (tag_arr[set] == tag);
  assign serve      = req && (state == IDLE) && hit;
  assign miss       = req && !((state == IDLE) && hit);
  assign start_miss = req && (state == IDLE) && !hit;

  always_comb begin
    state_nx  = state;
    mem_start = 1'b0;
    mem_we    = 1'b0;
    mem_line  = {tag, set};
    unique case (state)
      IDLE: begin
        if (start_miss) begin
          mem_start = 1'b1;
          if (valid[set] && dirty[set]) begin
            state_nx = SWAP_OUT;
            mem_we   = 1'b1;
            mem_line = {tag_arr[set], set};
          end else begin
            state_nx = SWAP_IN;
          end
        end
      end
      SWAP_OUT: begin
        if (mem_done) begin
          state_nx  = SWAP_IN;
          mem_start = 1'b1;
          mem_line  = {req_tag, req_set};
        end
      end
      SWAP_IN: begin
        if (mem_done)
          state_nx = SWAP_IN_OK;
      end
      SWAP_IN_OK: state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  line_mem_model #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .start    (mem_start),
    .we       (mem_we),
    .line_addr(mem_line),
    .wdata    (data[set]),
    .done     (mem_done),
    .rdata    (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      rd_data <= '0;
      req_tag <= '0;
      req_set <= '0;
    end else begin
      state <= state_nx;
      if (start_miss) begin
        req_tag <= tag;
        req_set <= set;
      end
      if (state == SWAP_IN_OK) begin
        valid[req_set] <= 1'b1;
        dirty[req_set] <= 1'b0;
      end
      if (serve && wr_req)
        dirty[set] <= 1'b1;
      if (serve && rd_req && !wr_req)
        rd_data <= data[set][{word, 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (state == SWAP_IN && mem_done)
      data[req_set] <= mem_rdata;
    if (state == SWAP_IN_OK)
      tag_arr[req_set] <= req_tag;
    if (serve && wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          data[set][{word, 2'(b), 3'b0} +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (serve)
        hit_count <= hit_count + 1'b1;
      if (start_miss)
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm_responder.sv
// Self-checking bench for dcache_dm_responder (MEM_LATENCY = 8).
// Cache/store model checked every cycle plus literal expectations.
module tb_dcache_dm_responder;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd_req, wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_dm_responder #(.MEM_LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .miss      (miss)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: backing store keyed by line*8+word, plus per-set cache state.
  logic [31:0] sm [int];
  logic [31:0] cd [8][8];
  bit          ck [8][8];
  bit          mv [8];
  bit          md [8];
  int          mt [8];
  logic [31:0] exp_rd;
  bit          rd_known;
  int          exp_pen;
  int          start_tick;
  int          tick;
  bit          active;
  int          hc, mc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rd_known)
      chk("rd_data", rd_data, exp_rd);
    if (active)
      chk("miss", {31'b0, miss}, ((tick - start_tick) < exp_pen) ? 32'd1 : 32'd0);
    else
      chk("miss_idle", {31'b0, miss}, 32'd0);
    tick++;
  end

  // Cache-level effect of a request on a miss; returns expected penalty.
  task automatic model_fill(input logic [31:0] a, output int pen);
    int s, t;
    s = int'((a >> 5) & 32'd7);
    t = int'((a >> 8) & 32'd31);
    if (mv[s] && mt[s] == t) begin
      pen = 0;
    end else begin
      if (mv[s] && md[s]) begin
        pen = 2 * L + 2;
        for (int i = 0; i < 8; i++) begin
          if (ck[s][i]) sm[(mt[s] * 8 + s) * 8 + i] = cd[s][i];
          else if (sm.exists((mt[s] * 8 + s) * 8 + i))
            sm.delete((mt[s] * 8 + s) * 8 + i);
        end
      end else begin
        pen = L + 2;
      end
      for (int i = 0; i < 8; i++) begin
        if (sm.exists((t * 8 + s) * 8 + i)) begin
          cd[s][i] = sm[(t * 8 + s) * 8 + i];
          ck[s][i] = 1'b1;
        end else begin
          ck[s][i] = 1'b0;
        end
      end
      mv[s] = 1'b1;
      md[s] = 1'b0;
      mt[s] = t;
    end
  endtask

  task automatic model_done(input logic [31:0] a, input bit rd, input bit wr,
                            input logic [3:0] be, input logic [31:0] d);
    int s, w;
    s = int'((a >> 5) & 32'd7);
    w = int'((a >> 2) & 32'd7);
    if (wr) begin
      if (be == 4'hF) begin
        cd[s][w] = d;
        ck[s][w] = 1'b1;
      end else if (ck[s][w]) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) cd[s][w][b*8 +: 8] = d[b*8 +: 8];
      end
      md[s] = 1'b1;
    end else if (rd) begin
      exp_rd   = cd[s][w];
      rd_known = ck[s][w];
    end
  endtask

  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [3:0] be, input logic [31:0] d,
                        output int cnt);
    int pen;
    model_fill(a, pen);
    exp_pen    = pen;
    start_tick = tick;
    active     = 1'b1;
    addr    = a;
    rd_req  = rd;
    wr_req  = wr;
    wr_be   = be;
    wr_data = d;
    cnt = 0;
    @(negedge clk);
    while (miss === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("penalty", cnt, pen);
    @(posedge clk);
    #1;
    model_done(a, rd, wr, be, d);
    hc++;
    if (pen > 0) mc++;
    rd_req = 1'b0;
    wr_req = 1'b0;
    active = 1'b0;
  endtask

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, hc);
    chk("miss_count", miss_count, mc);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_rd   = 32'h0;
    rd_known = 1'b1;
    hc = 0;
    mc = 0;
  endtask

  initial begin
    int c;
    tick = 0; start_tick = 0; exp_pen = 0; active = 1'b0;
    model_reset();
    rst = 1'b1; addr = '0; rd_req = 1'b0; wr_req = 1'b0;
    wr_be = 4'h0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_miss", {31'b0, miss}, 32'd0);
    rst = 1'b0;
    check_stats();

    access(32'h40, 1'b0, 1'b1, 4'hF, 32'hA0A0_0040, c);
    chk("lit_clean_miss", c, 32'd10);
    for (int i = 1; i < 8; i++)
      access(32'h40 + 32'(4 * i), 1'b0, 1'b1, 4'hF, 32'hA0A0_0040 + 32'(4 * i), c);
    chk("lit_hit_write", c, 32'd0);

    access(32'h440, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_dirty_miss", c, 32'd18);
    access(32'h40, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_refill", c, 32'd10);
    chk("lit_preload", rd_data, 32'hA0A0_0040);

    access(32'h44, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, c);
    chk("lit_store_hit", c, 32'd0);
    access(32'h44, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_load_44", rd_data, 32'hDEAD_BEEF);

    access(32'h40, 1'b0, 1'b1, 4'hF, 32'h0000_0011, c);
    access(32'h440, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_evict2", c, 32'd18);
    access(32'h40, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_reload", c, 32'd10);
    chk("lit_wb_data", rd_data, 32'h0000_0011);
    check_stats();

    access(32'h48, 1'b0, 1'b1, 4'hF, 32'h1234_5678, c);
    access(32'h48, 1'b0, 1'b1, 4'b0100, 32'h00AB_0000, c);
    access(32'h48, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_byte_store", rd_data, 32'h12AB_5678);

    access(32'h4C, 1'b1, 1'b1, 4'hF, 32'h5555_AAAA, c);
    chk("lit_rdwr_hold", rd_data, 32'h12AB_5678);
    access(32'h4C, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_rdwr_data", rd_data, 32'h5555_AAAA);
    check_stats();

    // Reset during the fourth SWAP_IN cycle of a clean miss.
    exp_pen    = L + 2;
    start_tick = tick;
    active     = 1'b1;
    addr   = 32'hA0;
    rd_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("miss_before_rst", {31'b0, miss}, 32'd1);
    rst    = 1'b1;
    rd_req = 1'b0;
    active = 1'b0;
    model_reset();
    #1;
    chk("miss_after_rst", {31'b0, miss}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_stats();

    access(32'hA0, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_retry", c, 32'd10);
    access(32'h40, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_lost_wb_miss", c, 32'd10);
    chk("lit_lost_wb_data", rd_data, 32'h0000_0011);
    access(32'h48, 1'b1, 1'b0, 4'h0, 32'h0, c);
    chk("lit_old_48", rd_data, 32'hA0A0_0048);
    check_stats();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_dm_responder.md
Name: dcache_dm_responder

Overview:
- Responder end of the MEM/WB data-access interface: a direct-mapped, write-back, write-allocate data cache.
- Inputs are `addr`, `rd_req` and `wr_req` (`wr_data` is pre-shifted by byte lane). It returns `rd_data` one cycle later and holds `miss` high while a line refill or writeback is in progress.
- Holds an internal backing line store with fixed access latency. It is the block the WB data path instantiates as its data memory.

Parameters:
- LINE_ADDR_LEN, 3: log2 of words per line.
- SET_ADDR_LEN, 3: log2 of number of sets.
- TAG_ADDR_LEN, 5: tag width. Backing store holds 2^(TAG_ADDR_LEN+SET_ADDR_LEN) lines.
- MEM_LATENCY, 8: cycles per backing-store line transfer, minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- addr  in  32  byte address. Fields from bit 2 up: word-in-line, set, tag. addr[1:0] and bits above the tag are ignored.
- rd_req  in  1  load request.
- wr_req  in  1  store request.
- wr_be  in  4  byte enables for the store. Tie to 4'hF for full-word stores.
- wr_data  in  32  store data, already lane-aligned.
- rd_data  out  32  word read, registered.
- miss  out  1  request not yet serviced; requester holds all inputs stable while high.

Reset and clocking:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.

Behaviour:
- Reset values: state=IDLE, all valid and dirty bits 0, rd_data=0, latency counter 0. miss is combinational and therefore 0 with no request. Backing-store and cache-data arrays are not reset.
- miss = (rd_req|wr_req) & ~(state==IDLE & hit), where hit = valid[set] & tag_arr[set]==tag.
- Read hit: at the rising edge, rd_data <= line[set][word]. The value is valid the cycle after the request, so the requester samples it alongside its registered addr and load type. Latency is 1.
- Write hit: at the edge, bytes with wr_be=1 are written and dirty[set] <= 1. rd_data is unchanged.
- No request: rd_data holds its last value.
- Simultaneous rd_req and wr_req: treated as a write; rd_data is unchanged.
- FSM:
  - IDLE: on request & ~hit, go to SWAP_OUT if valid & dirty, else SWAP_IN. Latch victim tag and request line address.
  - SWAP_OUT: count MEM_LATENCY cycles, then write the victim line to the store at {victim_tag,set}, then go to SWAP_IN.
  - SWAP_IN: count MEM_LATENCY cycles, then read line {tag,set} from the store into the cache array, then go to SWAP_IN_OK.
  - SWAP_IN_OK: valid <= 1, dirty <= 0, tag_arr <= tag, then go to IDLE. The held request now hits and completes on the following edge.
- Miss penalty: clean miss is MEM_LATENCY+2 cycles of miss=1; dirty miss is 2·MEM_LATENCY+2.
- Counter saturation is not applicable: the counter is reloaded at each state entry.
- If the requester drops its request mid-miss, the FSM still completes the refill.
- Reset mid-operation: immediate return to IDLE and all lines invalidated. A pending writeback is lost; this is acceptable for the CPU test flow.
- A fill arriving in the same cycle as a new request cannot occur, because the request is held.

Optional Feature:
- DCACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - Both reset to 0.
  - miss_count increments once per IDLE→SWAP_* transition.
  - hit_count increments on each serviced request with miss=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK};
  - field-offset localparams derived from the parameters;
  - line-width constant (32·2^LINE_ADDR_LEN).
- One sub-module, line_mem_model: a single-port backing line store with start/done handshake and a MEM_LATENCY counter. The cache FSM drives start and waits for done.

Test Plan (MEM_LATENCY=8):
- After reset, rd_req at 0x0000_0040 → miss high for 10 cycles, then low. rd_data next cycle equals store preload word 0x40.
- Store 0xDEADBEEF at 0x44 with wr_be=F (hit after the line is resident) → miss=0. A load at 0x44 next cycle gives rd_data=0xDEADBEEF on the following cycle.
- Dirty eviction: write 0x11 to 0x0000_0040, then read 0x0000_0440 (same set, different tag) → miss for 18 cycles. Re-reading 0x40 later returns 0x11 after a 10-cycle miss.
- Byte store: wr_be=4'b0100, wr_data=0x00AB_0000 at 0x48 with prior word 0x12345678 → subsequent read gives 0x12AB5678.
- rst asserted in cycle 4 of SWAP_IN → miss drops when the request drops. A retried request misses again with the full 10 cycles.
- With DCACHE_STATS_EN: the above sequence yields exact hit_count and miss_count values checked by the scoreboard, e.g. 3 misses for the eviction scenario.
